// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w) + 1;
    endfunction

    function automatic int ss_idx_w(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: half-period down-counter plus SCLK edge counter.
// lead/trail/done are only asserted on ticks while in the transfer phase.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [DIV_W-1:0]              div_i,
    input  logic                          run_i,
    input  logic                          xfer_i,
    output logic                          tick_o,
    output logic [edge_cnt_w(DATA_W)-1:0] edge_idx_o,
    output logic                          lead_o,
    output logic                          trail_o,
    output logic                          done_o
);

    localparam int EW = edge_cnt_w(DATA_W);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic             edge_tick;

    assign tick_o     = run_i && (cnt_q == '0);
    assign edge_tick  = tick_o && xfer_i;
    // edge_q counts edges already produced, so the edge being made now is edge_q+1
    assign lead_o     = edge_tick && !edge_q[0];
    assign trail_o    = edge_tick && edge_q[0];
    assign done_o     = edge_tick && (edge_q == EW'(2 * DATA_W - 1));
    assign edge_idx_o = edge_q;

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        edge_d = edge_q;
        if (load_i) begin
            div_d  = div_i;
            cnt_d  = div_i;
            edge_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
            if (edge_tick) begin
                edge_d = edge_q + EW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four modes, MSB/LSB-first, one-hot slave selects.
// Word and config are latched on accept; rx_valid pulses once per completed transfer.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_W-1:0]           tx_data,
    input  logic [ss_idx_w(NUM_SS)-1:0] ss_sel,
    input  logic                        cpol,
    input  logic                        cpha,
    input  logic                        lsb_first,
    input  logic [DIV_W-1:0]            clk_div,
    input  logic                        miso,
    output logic                        sclk,
    output logic                        mosi,
    output logic [NUM_SS-1:0]           ss_n,
    output logic                        busy,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid
);

    localparam int SS_W = ss_idx_w(NUM_SS);
    localparam int EW   = edge_cnt_w(DATA_W);

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sample_q, sample_d;

    logic [NUM_SS-1:0] ss_dec_n;
    logic [DATA_W-1:0] rx_in;
    logic              accept;
    logic              tick;
    logic              lead;
    logic              trail;
    logic              done;
    logic [EW-1:0]     edge_idx;
    logic              last_edge;
    logic              samp_lead;
    logic              sample_edge;
    logic              drive_edge;

    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // Out-of-range indices match no line, so the transfer runs with every select high
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign ss_dec_n[gi] = (ss_sel != SS_W'(gi));
        end
    endgenerate

    spi_sclk_gen #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .div_i      (clk_div),
        .run_i      (state_q != ST_IDLE),
        .xfer_i     (state_q == ST_XFER),
        .tick_o     (tick),
        .edge_idx_o (edge_idx),
        .lead_o     (lead),
        .trail_o    (trail),
        .done_o     (done)
    );

    assign last_edge   = (edge_idx == EW'(2 * DATA_W - 1));
    assign samp_lead   = (mode_q == MODE0) || (mode_q == MODE2);
    assign sample_edge = samp_lead ? lead : trail;
    // cpha=0 presents bit 0 at select time, so the final trailing edge has nothing left to drive
    assign drive_edge  = samp_lead ? (trail && !last_edge) : lead;

    assign rx_in = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lsb_d      = lsb_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = sample_q ? rx_in : rx_sh_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        sample_d   = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol;
                if (start) begin
                    accept  = 1'b1;
                    mode_d  = {cpol, cpha};
                    lsb_d   = lsb_first;
                    rx_sh_d = '0;
                    ss_n_d  = ss_dec_n;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                    if (!cpha) begin
                        mosi_d  = head_bit(tx_data, lsb_first);
                        tx_sh_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d   = ~sclk_q;
                    sample_d = sample_edge;
                    if (drive_edge) begin
                        mosi_d  = head_bit(tx_sh_q, lsb_q);
                        tx_sh_d = shift_out(tx_sh_q, lsb_q);
                    end
                    if (done) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A capture pending from the final edge is folded into rx_sh_d before publishing
                if (tick) begin
                    state_d    = ST_IDLE;
                    ss_n_d     = '1;
                    busy_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE0;
            lsb_q      <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sample_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lsb_q      <= lsb_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            sample_q   <= sample_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master for the CPU-side peripheral bus. It supports configurable word width, SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first ordering and multiple one-hot slave selects. The CPU loads a word with a start pulse, then receives the slave's word with a one-cycle rx_valid strobe. Intended to replace fixed 8-bit, mode-0, single-slave usage throughout the design.

Parameters:
DATA_W, 8, bits per transfer (2..32)
NUM_SS, 4, number of slave-select lines (1..16)
DIV_W, 8, width of the clk_div input

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  request transfer; accepted only in IDLE
tx_data  in  DATA_W  word to transmit, latched on accept
ss_sel  in  $clog2(NUM_SS) (min 1)  slave index, latched on accept
cpol  in  1  SCLK idle level, latched on accept
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accept
lsb_first  in  1  bit order, latched on accept
clk_div  in  DIV_W  SCLK half-period = clk_div+1 clk cycles, latched on accept
miso  in  1  serial data from slave
sclk  out  1  serial clock (registered)
mosi  out  1  serial data to slave (registered)
ss_n  out  NUM_SS  active-low selects, at most one low
busy  out  1  high from cycle after accept until rx_valid cycle (exclusive)
rx_data  out  DATA_W  received word, held until next rx_valid
rx_valid  out  1  one-cycle strobe: rx_data updated, transfer complete

Behaviour:
- Reset values: sclk=0, mosi=0, ss_n=all 1, busy=0, rx_data=0, rx_valid=0, FSM=IDLE, all counters 0. rst mid-transfer aborts immediately with no rx_valid.
- Half-period H = clk_div+1 cycles, timed by a down-counter reloaded at each tick. clk_div=0 gives sclk = clk/2.
- IDLE: sclk tracks the cpol input (registered), ss_n all high. start while busy is ignored and not queued.
- Accept (start=1 in IDLE): latch tx_data into the shift register and latch all config. Next cycle: busy=1, ss_n[ss_sel]=0, go to SETUP. If cpha=0, mosi = first bit (MSB, or LSB if lsb_first).
- SETUP: lasts H cycles with sclk=cpol, then go to XFER.
- XFER: sclk toggles every H cycles for exactly 2*DATA_W edges (edge counter width $clog2(2*DATA_W)+1).
  - Sample edges: odd edges (1,3,..) if cpha=0; even edges if cpha=1. miso is captured on the clk edge one cycle after the sample edge appears on sclk, so it is captured no later than the next toggle.
  - Shift edges: cpha=0 drives the next bit on even edges; the last edge drives nothing. cpha=1 drives bit k on odd edge 2k+1.
  - Received bits are assembled in the same order as transmitted: rx bit 0 arrives first when lsb_first.
- HOLD: after edge 2*DATA_W, sclk=cpol and ss_n stays asserted for H cycles. Then in one cycle: ss_n all high, busy=0, rx_valid=1, rx_data=assembled word; return to IDLE.
- start is acceptable again in the rx_valid cycle; a back-to-back transfer has at least one deasserted-ss cycle.
- Latency from accept cycle to rx_valid = 1 + (2*DATA_W+2)*H cycles (DATA_W=8, H=1: 19).
- ss_sel >= NUM_SS: the transfer runs with all ss_n high and completes normally.
- Config input changes during busy have no effect.

Decomposition:
- Package spi_pkg: FSM state enum (IDLE, SETUP, XFER, HOLD), mode constants MODE0..MODE3 as {cpol,cpha}, and a function for the edge-counter width.
- One sub-module, spi_sclk_gen: half-period divider plus edge counter. Outputs tick, edge_idx, lead/trail flags and done.
- Shifter and FSM stay in the top module.

Test Plan:
- Mode 0, MSB-first, clk_div=0, tx=8'hA5, miso looped to mosi -> rx_valid 19 cycles after accept, rx_data=8'hA5, exactly 16 sclk toggles, ss_n=4'b1110 only while busy.
- Mode 3, slave model returning 8'h3C, ss_sel=2, clk_div=3 -> sclk idle high, H=4 cycles, ss_n=4'b1011, mosi bits change on falling edges, rx_data=8'h3C, latency 1+18*4=73.
- Mode 1, lsb_first, tx=8'h01, slave returns 8'h80 LSB-first -> first mosi bit 1, rx_data=8'h80.
- start pulsed during busy and again on the rx_valid cycle -> first pulse ignored, second accepted, ss_n high for at least one cycle between transfers.
- rst asserted at edge 7 of a transfer -> next cycle sclk=0, ss_n all high, busy=0, no rx_valid, rx_data=0.
- DATA_W=16 build, mode 2, tx=16'hBEEF loopback -> 32 toggles, rx_data=16'hBEEF.
